// File: rtl/pm_read_arbiter.sv
// Round-robin arbiter that shares one page-mode read engine among NREQ clients,
// steering word strobes and completion status back to the current owner.
module pm_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 22,
    parameter int LW   = 3,
    parameter int TOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    input  logic [NREQ*LW-1:0]   len_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      word_valid_o,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      err_o,
    output logic [AW-1:0]        pm_address_o,
    output logic [LW-1:0]        pm_length_o,
    output logic                 pm_start_o,
    input  logic                 pm_busy_i,
    input  logic                 pm_word_strobe_i
);
    localparam int IW = $clog2(NREQ);
    localparam int WW = $clog2(TOUT + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_RUN, S_COMPLETE, S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW-1:0]   len_q, len_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            tout_q, tout_d;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic            wdog_expired;
    logic            mismatch;
    logic            in_run;
    logic            in_complete;
    logic            err_flag;

    // First asserted request at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // wdog_q holds cycles elapsed since the last sign of progress (start or strobe).
    assign wdog_expired = (wdog_q >= WDOG_LAST);
    assign mismatch     = (int'(cnt_q) != int'(len_q) + 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        addr_d  = addr_q;
        len_d   = len_q;
        wdog_d  = wdog_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        case (state_q)
            S_IDLE: begin
                if (!pm_busy_i && found) begin
                    owner_d      = win;
                    gnt_d        = '0;
                    gnt_d[win]   = 1'b1;
                    ack_d[win]   = 1'b1;
                    addr_d       = addr_i[int'(win)*AW +: AW];
                    len_d        = len_i[int'(win)*LW +: LW];
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = WW'(1);
                cnt_d   = '0;
                tout_d  = 1'b0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (pm_busy_i) begin
                    wdog_d  = wdog_q + WW'(1);
                    state_d = S_RUN;
                end else if (wdog_expired) begin
                    tout_d  = 1'b1;
                    state_d = S_COMPLETE;
                end else begin
                    wdog_d  = wdog_q + WW'(1);
                end
            end
            S_RUN: begin
                if (pm_word_strobe_i) begin
                    cnt_d  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                    wdog_d = WW'(1);
                end
                if (!pm_busy_i) begin
                    state_d = S_COMPLETE;
                end else if (!pm_word_strobe_i) begin
                    if (wdog_expired) begin
                        tout_d  = 1'b1;
                        state_d = S_COMPLETE;
                    end else begin
                        wdog_d  = wdog_q + WW'(1);
                    end
                end
            end
            S_COMPLETE: begin
                gnt_d   = '0;
                ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
                state_d = tout_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!pm_busy_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wdog_q  <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdog_q  <= wdog_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    assign in_run       = (state_q == S_RUN);
    assign in_complete  = (state_q == S_COMPLETE);
    assign err_flag     = tout_q | mismatch;
    assign pm_start_o   = (state_q == S_ISSUE);
    assign pm_address_o = addr_q;
    assign pm_length_o  = len_q;

    // Per-client steering; strobes outside RUN never reach a client.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_client
        assign ack_o[gi]        = ack_q[gi];
        assign gnt_o[gi]        = gnt_q[gi];
        assign word_valid_o[gi] = pm_word_strobe_i & gnt_q[gi] & in_run;
        assign done_o[gi]       = gnt_q[gi] & in_complete;
        assign err_o[gi]        = gnt_q[gi] & in_complete & err_flag;
    end

endmodule

// File: tb/tb_pm_read_arbiter.sv
// Testbench for pm_read_arbiter: directed vector table, timeout and reset sequences,
// then random transactions checked against a round-robin reference model.
module tb_pm_read_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 22;
    localparam int LW   = 3;
    localparam int TOUT = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*LW-1:0]  len;
    logic [NREQ-1:0]     ack, gnt, wv, done, err;
    logic [AW-1:0]       pm_addr;
    logic [LW-1:0]       pm_len;
    logic                pm_start;
    logic                busy;
    logic                strobe;

    int checks   = 0;
    int failures = 0;
    int model_ptr = 0;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [AW-1:0]   addr;
        logic [LW-1:0]   len;
        int              nstr;
        bit              coin;
        int              owner;
        bit              err;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    pm_read_arbiter #(.NREQ(NREQ), .AW(AW), .LW(LW), .TOUT(TOUT)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req),
        .addr_i           (addr),
        .len_i            (len),
        .ack_o            (ack),
        .gnt_o            (gnt),
        .word_valid_o     (wv),
        .done_o           (done),
        .err_o            (err),
        .pm_address_o     (pm_addr),
        .pm_length_o      (pm_len),
        .pm_start_o       (pm_start),
        .pm_busy_i        (busy),
        .pm_word_strobe_i (strobe)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference arbitration: scan clients starting at the pointer, wrapping.
    function automatic int model_winner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ack !== '0) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic load_ports(input logic [AW-1:0] abase, input logic [LW-1:0] ln, input int owner);
        for (int i = 0; i < NREQ; i++) begin
            addr[i*AW +: AW] = (i == owner) ? abase : abase ^ AW'(i + 1);
            len[i*LW +: LW]  = (i == owner) ? ln : ~ln;
        end
    endtask

    task automatic run_txn(input logic [NREQ-1:0] r, input logic [AW-1:0] abase,
                           input logic [LW-1:0] ln, input int nstr, input bit coin,
                           input bit junk, input int gapmax, input int exp_owner,
                           input bit exp_err);
        logic [NREQ-1:0] oh;
        bit got;
        int gap;
        oh = '0;
        oh[exp_owner] = 1'b1;
        load_ports(abase, ln, exp_owner);
        req = r;
        wait_ack(got);
        if (!got) begin
            req = '0;
            return;
        end
        chk("ack_onehot", 32'(ack), 32'(oh));
        chk("gnt_onehot", 32'(gnt), 32'(oh));
        chk("pm_start", 32'(pm_start), 32'd1);
        chk("pm_address", 32'(pm_addr), 32'(abase));
        chk("pm_length", 32'(pm_len), 32'(ln));
        req[exp_owner] = 1'b0;
        busy = 1'b1;
        step();
        chk("start_one_cycle", 32'(pm_start), 32'd0);
        chk("ack_one_cycle", 32'(ack), 32'd0);
        if (junk) begin
            strobe = 1'b1;
            #1;
            chk("wv_outside_run", 32'(wv), 32'd0);
        end
        step();
        strobe = 1'b0;
        for (int s = 0; s < nstr; s++) begin
            gap = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
            repeat (gap) step();
            strobe = 1'b1;
            if (coin && s == nstr - 1) busy = 1'b0;
            #1;
            chk("word_valid", 32'(wv), 32'(oh));
            step();
            strobe = 1'b0;
        end
        if (!(coin && nstr > 0)) begin
            gap = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
            repeat (gap) step();
            busy = 1'b0;
            step();
        end
        chk("done", 32'(done), 32'(oh));
        chk("err", 32'(err), exp_err ? 32'(oh) : 32'd0);
        chk("gnt_held", 32'(gnt), 32'(oh));
        $display("txn req=%b owner=%0d len=%0d strobes=%0d coin=%0d err=%0d",
                 r, exp_owner, ln, nstr, coin, exp_err);
        model_ptr = (exp_owner + 1) % NREQ;
        step();
        chk("done_pulse", 32'(done), 32'd0);
        chk("gnt_dropped", 32'(gnt), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit got;
        bit bad;
        int w;
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] r;
        logic [LW-1:0] ln;
        int nstr;

        tbl[0] = '{4'b0100, 22'h00ABCD, 3'd3, 4, 1'b0, 2, 1'b0};
        tbl[1] = '{4'b1111, 22'h000100, 3'd0, 1, 1'b0, 3, 1'b0};
        tbl[2] = '{4'b1111, 22'h000200, 3'd0, 1, 1'b0, 0, 1'b0};
        tbl[3] = '{4'b1111, 22'h000300, 3'd0, 1, 1'b0, 1, 1'b0};
        tbl[4] = '{4'b1111, 22'h000400, 3'd0, 1, 1'b0, 2, 1'b0};
        tbl[5] = '{4'b0011, 22'h155555, 3'd7, 6, 1'b0, 0, 1'b1};
        tbl[6] = '{4'b0011, 22'h2AAAAA, 3'd1, 2, 1'b1, 1, 1'b0};
        tbl[7] = '{4'b1000, 22'h3FFFFF, 3'd5, 7, 1'b0, 3, 1'b1};
        tbl[8] = '{4'b0001, 22'h000000, 3'd0, 0, 1'b0, 0, 1'b1};

        rst_n  = 1'b0;
        req    = 4'b1111;
        addr   = '1;
        len    = '1;
        busy   = 1'b0;
        strobe = 1'b1;
        repeat (3) step();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wv", 32'(wv), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_start", 32'(pm_start), 32'd0);
        chk("rst_addr", 32'(pm_addr), 32'd0);
        chk("rst_len", 32'(pm_len), 32'd0);
        req    = '0;
        strobe = 1'b0;
        rst_n  = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].req, tbl[i].addr, tbl[i].len, tbl[i].nstr, tbl[i].coin,
                    1'b0, 0, tbl[i].owner, tbl[i].err);
        end

        // Engine never answers: watchdog completes with error, then drain.
        r = 4'b0010;
        w = model_winner(r, model_ptr);
        oh = '0;
        oh[w] = 1'b1;
        load_ports(22'h012345, 3'd2, w);
        req = r;
        wait_ack(got);
        chk("tout_ack", 32'(ack), 32'(oh));
        req = '0;
        for (int k = 1; k <= TOUT; k++) begin
            step();
            if (k == TOUT - 1) chk("tout_not_early", 32'(done), 32'd0);
        end
        chk("tout_done", 32'(done), 32'(oh));
        chk("tout_err", 32'(err), 32'(oh));
        $display("txn req=%b owner=%0d timeout", r, w);
        model_ptr = (w + 1) % NREQ;
        step();
        busy = 1'b1;
        req  = 4'b0001;
        bad  = 1'b0;
        repeat (20) begin
            step();
            if (ack !== '0 || gnt !== '0) bad = 1'b1;
        end
        chk("drain_no_grant", 32'(bad), 32'd0);
        busy = 1'b0;
        run_txn(4'b0001, 22'h0F0F0F, 3'd1, 2, 1'b0, 1'b0, 0,
                model_winner(4'b0001, model_ptr), 1'b0);

        // Asynchronous reset in the middle of a burst.
        r = 4'b0100;
        w = model_winner(r, model_ptr);
        oh = '0;
        oh[w] = 1'b1;
        load_ports(22'h001234, 3'd3, w);
        req = r;
        wait_ack(got);
        req  = '0;
        busy = 1'b1;
        step();
        step();
        strobe = 1'b1;
        #1;
        chk("pre_reset_wv", 32'(wv), 32'(oh));
        rst_n = 1'b0;
        #1;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_wv", 32'(wv), 32'd0);
        chk("reset_start", 32'(pm_start), 32'd0);
        $display("txn req=%b owner=%0d aborted by reset", r, w);
        step();
        step();
        strobe = 1'b0;
        busy   = 1'b0;
        rst_n  = 1'b1;
        model_ptr = 0;
        step();
        run_txn(4'b1010, 22'h00BEEF, 3'd0, 1, 1'b0, 1'b0, 0, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r    = NREQ'($urandom_range(15, 1));
            ln   = LW'($urandom_range(7, 0));
            nstr = ($urandom_range(1, 0) == 1) ? int'(ln) + 1 : $urandom_range(10, 0);
            w    = model_winner(r, model_ptr);
            run_txn(r, AW'($urandom), ln, nstr, 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), 3, w, (nstr != int'(ln) + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
